// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding imem requests,
// 2-entry skid FIFO toward decode, redirect with stale-response drain.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc,
    output logic [PC_W-1:0]   if_pc_plus1,
    input  logic              id_ready,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc
);

    typedef enum logic {
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_req_addr;
    logic              r_outst;
    logic              w_outst_nxt;
    logic [1:0]        r_count;
    logic [1:0]        w_count_nxt;
    logic [INST_W-1:0] r_inst0;
    logic [INST_W-1:0] r_inst1;
    logic [PC_W-1:0]   r_pc0;
    logic [PC_W-1:0]   r_pc1;
    logic [PC_W-1:0]   r_pcp0;
    logic [PC_W-1:0]   r_pcp1;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [PC_W-1:0]   w_rsp_plus1;

    assign w_pop  = (r_count != 2'd0) & id_ready & ~redirect;
    assign w_push = imem_rvalid & r_outst & (r_state == S_RUN) & ~redirect;

    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_rsp_plus1 = r_req_addr + 1'b1;

    // Issue only if the response is guaranteed a FIFO slot after this cycle's traffic
    assign w_issue = rst_n & fetch_en & ~redirect & (r_state == S_RUN)
                   & (~r_outst | imem_rvalid) & (w_count_nxt <= 2'd1);

    assign imem_req    = w_issue;
    assign imem_addr   = w_issue ? r_pc : '0;
    assign if_valid    = (r_count != 2'd0);
    assign if_inst     = r_inst0;
    assign if_pc       = r_pc0;
    assign if_pc_plus1 = r_pcp0;

    always_comb begin
        w_state_nxt = r_state;
        w_outst_nxt = r_outst;
        unique case (r_state)
            S_RUN: begin
                if (redirect) begin
                    if (r_outst & ~imem_rvalid) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_outst_nxt = 1'b0;
                    end
                end else if (w_issue) begin
                    w_outst_nxt = 1'b1;
                end else if (imem_rvalid) begin
                    w_outst_nxt = 1'b0;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_RUN;
                    w_outst_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_outst_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_outst    <= 1'b0;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_outst <= w_outst_nxt;
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_issue) begin
                r_req_addr <= r_pc;
            end
        end
    end

    // Slot 0 is the head; a push lands in slot (count - pop)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_inst0 <= '0;
            r_inst1 <= '0;
            r_pc0   <= '0;
            r_pc1   <= '0;
            r_pcp0  <= '0;
            r_pcp1  <= '0;
        end else if (redirect) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_nxt;
            if (w_pop) begin
                r_inst0 <= r_inst1;
                r_pc0   <= r_pc1;
                r_pcp0  <= r_pcp1;
            end
            if (w_push) begin
                if (w_count_nxt == 2'd1) begin
                    r_inst0 <= imem_rdata;
                    r_pc0   <= r_req_addr;
                    r_pcp0  <= w_rsp_plus1;
                end else begin
                    r_inst1 <= imem_rdata;
                    r_pc1   <= r_req_addr;
                    r_pcp1  <= w_rsp_plus1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: program-order reference stream,
// randomized memory latency, stalls, redirects and resets.
module tb_fetch_unit;

    localparam logic [7:0] RPC = 8'hFE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [7:0]  if_pc;
    logic [7:0]  if_pc_plus1;
    logic        id_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;

    fetch_unit #(
        .PC_W(8),
        .INST_W(16),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid),
        .if_inst(if_inst),
        .if_pc(if_pc),
        .if_pc_plus1(if_pc_plus1),
        .id_ready(id_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] inst;
    } exp_t;

    typedef struct {
        int         due;
        logic [7:0] addr;
    } rsp_t;

    int         total = 0;
    int         bad = 0;
    exp_t       exp_q[$];
    rsp_t       pend[$];
    logic [7:0] nxt_exp_pc;
    logic [7:0] exp_req_pc;
    int         cyc = 0;
    int         lat_min = 1;
    int         lat_max = 1;
    int         reqs = 0;
    int         pops = 0;
    int         handshakes = 0;
    bit         stray = 0;
    bit         mon_en = 0;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    function automatic void refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{pc: nxt_exp_pc, inst: mem_word(nxt_exp_pc)});
            nxt_exp_pc++;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        pend.delete();
        nxt_exp_pc = RPC;
        exp_req_pc = RPC;
        reqs = 0;
        pops = 0;
        refill();
    endfunction

    // One clock cycle: drive inputs at negedge, then check requests
    task automatic cycle(input bit rdy, input bit fen, input bit rdr,
                         input logic [7:0] rpc, input bit rst);
        bit legal;
        int lat;
        @(negedge clk);
        cyc++;
        rst_n       = !rst;
        fetch_en    = fen;
        id_ready    = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 16'hDEAD;
            stray       = 0;
        end else if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (rdr) begin
                exp_q.delete();
                nxt_exp_pc = rpc;
                exp_req_pc = rpc;
                reqs = 0;
                pops = 0;
            end else if (if_valid && rdy) begin
                pops++;
            end
            if (imem_req) begin
                legal = fen && !rdr && (pend.size() == 0);
                chk("req_legal", legal, 1);
                chk("req_addr", imem_addr, exp_req_pc);
                reqs++;
                chk("inflight_le2", (reqs - pops) <= 2, 1);
                exp_req_pc++;
                lat = $urandom_range(lat_max, lat_min);
                pend.push_back('{due: cyc + lat, addr: imem_addr});
            end
            refill();
        end
    endtask

    task automatic wait_req(output bit f);
        f = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 0, 8'h00, 0);
            if (imem_req) begin
                f = 1;
                return;
            end
        end
    endtask

    // Monitor: compares the FIFO head against the reference stream
    initial begin
        bit         prev_rdr = 0;
        bit         prev_rst = 1;
        logic [7:0] e1;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (prev_rdr || prev_rst) begin
                    chk("flush_empty", if_valid, 0);
                end else if (rst_n && !redirect && if_valid) begin
                    chk("exp_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e1 = exp_q[0].pc + 8'd1;
                        chk("head_pc", if_pc, exp_q[0].pc);
                        chk("head_inst", if_inst, exp_q[0].inst);
                        chk("head_pc1", if_pc_plus1, e1);
                        if (id_ready) begin
                            void'(exp_q.pop_front());
                            handshakes++;
                        end
                    end
                end
            end
            prev_rdr = redirect;
            prev_rst = !rst_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit f;
        int h0;
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        model_reset();
        mon_en = 1;
        cycle(1, 0, 0, 8'h00, 1);
        cycle(1, 0, 0, 8'h00, 1);

        // Reset state, 1-cycle memory streaming, PC wrap
        for (int k = 0; k < 10; k++) begin
            cycle(1, 1, 0, 8'h00, 0);
            chk("p1_req", imem_req, 1);
            if (k == 0) begin
                chk("rst_valid", if_valid, 0);
                chk("rst_inst", if_inst, 0);
                chk("rst_pc", if_pc, 0);
                chk("rst_pc1", if_pc_plus1, 0);
                chk("first_addr", imem_addr, RPC);
            end
            if (k == 1) chk("addr_ff", imem_addr, 8'hFF);
            if (k == 2) chk("addr_00", imem_addr, 8'h00);
            if (k == 3) chk("pc1_wrap", if_pc_plus1, 8'h00);
            if (k >= 2) chk("p1_valid", if_valid, 1);
        end

        // Decode stall then release
        for (int k = 0; k < 6; k++) cycle(0, 1, 0, 8'h00, 0);
        chk("stall_noreq", imem_req, 0);
        chk("stall_valid", if_valid, 1);
        h0 = handshakes;
        for (int k = 0; k < 8; k++) cycle(1, 1, 0, 8'h00, 0);
        chk("release_rate", (handshakes - h0) >= 6, 1);

        // Redirect while a 3-cycle request is outstanding
        lat_min = 3;
        lat_max = 3;
        wait_req(f);
        chk("p3_req_seen", f, 1);
        cycle(1, 1, 1, 8'h40, 0);
        wait_req(f);
        chk("p3_req_seen2", f, 1);
        chk("p3_addr", imem_addr, 8'h40);
        f = 0;
        for (int k = 0; k < 12 && !f; k++) begin
            cycle(1, 1, 0, 8'h00, 0);
            f = if_valid;
        end
        chk("p3_valid_seen", f, 1);
        chk("p3_head", if_pc, 8'h40);

        // Redirect coincident with a response
        lat_min = 2;
        lat_max = 2;
        f = 0;
        for (int k = 0; k < 12 && !f; k++) begin
            if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                cycle(1, 1, 1, 8'h20, 0);
                f = imem_rvalid;
            end else begin
                cycle(1, 1, 0, 8'h00, 0);
            end
        end
        chk("p4_rv_redirect", f, 1);
        cycle(1, 1, 0, 8'h00, 0);
        chk("p4_req", imem_req, 1);
        chk("p4_addr", imem_addr, 8'h20);
        chk("p4_empty", if_valid, 0);
        for (int k = 0; k < 6; k++) cycle(1, 1, 0, 8'h00, 0);

        // Reset with FIFO occupied and a request in flight
        lat_min = 3;
        lat_max = 3;
        f = 0;
        for (int k = 0; k < 20 && !f; k++) begin
            cycle(0, 1, 0, 8'h00, 0);
            f = if_valid && (pend.size() > 0);
        end
        chk("p6_busy_seen", f, 1);
        cycle(0, 1, 0, 8'h00, 1);
        stray = 1;
        cycle(1, 0, 0, 8'h00, 0);
        chk("p6_valid", if_valid, 0);
        chk("p6_inst", if_inst, 0);
        chk("p6_pc", if_pc, 0);
        chk("p6_pc1", if_pc_plus1, 0);
        chk("p6_noreq", imem_req, 0);
        cycle(1, 1, 0, 8'h00, 0);
        chk("p6_req", imem_req, 1);
        chk("p6_addr", imem_addr, RPC);
        for (int k = 0; k < 10; k++) cycle(1, 1, 0, 8'h00, 0);

        // Randomized traffic
        lat_min = 1;
        lat_max = 3;
        h0 = handshakes;
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 19) == 0,
                  8'($urandom), 0);
        end
        chk("rand_progress", (handshakes - h0) > 500, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
